// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the pipeline's
// Memory stage (priority) and a host/debug requester.
// Optional feature macro: DMEM_ARB_STARVE_EN enables the starvation guard,
// which forces a one-cycle host slot by stalling the core after the host
// has been refused STARVE_LIMIT consecutive cycles.
//
// Host handshake (valid/ready): a transfer happens on any cycle where
// host_valid & host_ready. Once host_valid is raised it stays high, and all
// host_* fields stay stable, until the transfer cycle. host_ready is purely
// combinational and may depend on host_valid. Reads answer one cycle after
// the transfer via host_rvalid/host_rdata; writes produce no response.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  // Memory-stage side
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [31:0]   core_wdata,
  input  logic [2:0]    core_be,
  output logic [31:0]   core_rdata,
  output logic          core_stall,
  // Host/debug side
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  input  logic [2:0]    host_be,
  output logic          host_rvalid,
  output logic [31:0]   host_rdata,
  // dmem pins
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  output logic [2:0]    mem_be,
  input  logic [31:0]   mem_rd
);

  logic grant_host;
  logic force_slot;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] wait_cnt;

  assign force_slot = (wait_cnt == CW'(STARVE_LIMIT));

  // Count consecutive refused host cycles; saturate, clear on transfer or idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (host_valid && !grant_host) begin
      if (wait_cnt != CW'(STARVE_LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  // Guard compiled out: a slot is never forced, so the host only gets
  // cycles the core leaves free. STARVE_LIMIT is kept for a stable interface.
  assign force_slot = 1'b0 && (STARVE_LIMIT > 0);
`endif

  // Core has priority unless the starvation guard forces a host slot
  assign grant_host = host_valid && (!core_req || force_slot);
  assign host_ready = grant_host;
  assign core_stall = core_req && grant_host;

  // dmem read data goes straight back; the core ignores it while stalled
  assign core_rdata = mem_rd;

  // Port mux: host fields in a granted cycle, core fields otherwise
  always_comb begin
    mem_we = core_req && core_we;
    mem_a  = core_addr;
    mem_wd = core_wdata;
    mem_be = core_be;
    if (grant_host) begin
      mem_we = host_we;
      mem_a  = host_addr;
      mem_wd = host_wdata;
      mem_be = host_be;
    end
  end

  // Register host read data one cycle after an accepted read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= grant_host && !host_we;
      if (grant_host && !host_we) begin
        host_rdata <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus random stimulus for dmem_arbiter, checked
// against a word-level model of the shared memory and the host arbitration
// rules. Build with DMEM_ARB_STARVE_EN to exercise the starvation guard.
module tb_dmem_arbiter;

  localparam int LIMIT = 8;
  localparam int AW    = 32;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic preload;
  always #5 clk = ~clk;

  logic          core_req, core_we, core_stall;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata, core_rdata;
  logic [2:0]    core_be;
  logic          host_valid, host_ready, host_we, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata, host_rdata;
  logic [2:0]    host_be;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd, mem_rd;
  logic [2:0]    mem_be;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_be(host_be),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_be(mem_be),
    .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  function automatic logic [7:0] widx(logic [AW-1:0] a);
    return a[9:2];
  endfunction

  // Simple word-wide dmem attached to the arbiter's memory port
  logic [31:0] dmem [0:255];
  assign mem_rd = dmem[widx(mem_a)];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
    end else if (mem_we) begin
      dmem[widx(mem_a)] <= mem_wd;
    end
  end

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [0:255];
  int refused;
  bit exp_rv;
  bit last_g;
  bit last_stall;
  bit obs_stall;
  bit prev_obs_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    refused = 0;
    exp_rv  = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: inputs are already driven (we sit just after negedge)
  task automatic step();
    bit g;
    logic [31:0] rd_exp;
    #1;
    g = host_valid && (!core_req || (STARVE_EN && refused == LIMIT));
    rd_exp = model_mem[g ? widx(host_addr) : widx(core_addr)];
    check("host_ready", host_ready, g);
    check("core_stall", core_stall, core_req && g);
    check("mem_we", mem_we, g ? host_we : (core_req && core_we));
    check("mem_a", mem_a, g ? host_addr : core_addr);
    check("mem_wd", mem_wd, g ? host_wdata : core_wdata);
    check("mem_be", mem_be, g ? host_be : core_be);
    check("core_rdata", core_rdata, rd_exp);
    prev_obs_stall = obs_stall;
    obs_stall = core_stall;
    @(posedge clk);
    exp_rv = g && !host_we;
    if (exp_rv) exp_q.push_back(rd_exp);
    if (g && host_we) model_mem[widx(host_addr)] = host_wdata;
    else if (!g && core_req && core_we) model_mem[widx(core_addr)] = core_wdata;
    if (host_valid && !g) refused = (refused < LIMIT) ? refused + 1 : LIMIT;
    else refused = 0;
    last_g = g;
    last_stall = core_req && g;
    @(negedge clk);
    check("host_rvalid", host_rvalid, exp_rv);
    if (exp_rv && exp_q.size() > 0) check("host_rdata", host_rdata, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_be = 3'd2;
    host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_be = 3'd2;
  endtask

  task automatic set_host(input bit we, input logic [31:0] addr, input logic [31:0] data);
    host_valid = 1; host_we = we; host_addr = addr; host_wdata = data; host_be = 3'd2;
  endtask

  // Core loads every cycle (stopping after 'busy' cycles without the guard)
  // while a host request is pending; reports the accept cycle and stalls.
  task automatic run_stream(input int busy, output int acc, output int stalls);
    acc = 0;
    stalls = 0;
    for (int c = 1; c <= busy + 4 && acc == 0; c++) begin
      core_req = (STARVE_EN || c <= busy);
      core_we = 0;
      core_addr = 32'h100;
      step();
      if (obs_stall) stalls++;
      if (last_g) acc = c;
    end
    host_valid = 0;
    core_req = 0;
  endtask

  task automatic reset_pulse();
    reset = 1;
    #1;
    check("rst_rvalid", host_rvalid, 0);
    check("rst_rdata", host_rdata, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int acc, stalls, rv_cnt;
    drive_idle();
    reset = 1;
    preload = 1;
    model_reset();
    last_g = 0; last_stall = 0; obs_stall = 0; prev_obs_stall = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    @(posedge clk);
    @(negedge clk);
    preload = 0;
    check("reset_rvalid", host_rvalid, 0);
    check("reset_rdata", host_rdata, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_ready", host_ready, 0);
    check("reset_stall", core_stall, 0);
    reset = 0;

    // Idle core, host read of 0x40 after the core stores 0xDEADBEEF there
    core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'hDEADBEEF;
    step();
    core_req = 0; core_we = 0;
    set_host(0, 32'h40, 0);
    #1 check("t1_ready", host_ready, 1);
    step();
    host_valid = 0;
    check("t1_rdata", host_rdata, 32'hDEADBEEF);

    // Host write behind a busy core
    set_host(1, 32'h80, 32'h12345678);
    run_stream(12, acc, stalls);
    check("t2_accept_cycle", acc, STARVE_EN ? LIMIT + 1 : 13);
    check("t2_stalls", stalls, STARVE_EN ? 1 : 0);
    core_req = 1; core_we = 0; core_addr = 32'h80;
    #1 check("t2_readback", core_rdata, 32'h12345678);
    step();
    core_req = 0;

    // Core store and host write to the same word, counter at 0
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hAAAA5555;
    set_host(1, 32'h10, 32'h0);
    step();
    check("t3_core_wins", dmem[4], 32'hAAAA5555);
    core_req = 0; core_we = 0;
    step();
    check("t3_host_next", last_g, 1);
    check("t3_host_wrote", dmem[4], 32'h0);
    host_valid = 0;

    // Back-to-back host reads with an idle core
    rv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      set_host(0, 32'(i * 4), 0);
      step();
      if (host_rvalid) rv_cnt++;
    end
    host_valid = 0;
    check("t4_rvalid_run", rv_cnt, 3);

    // Reset while a read response is valid
    set_host(0, 32'h20, 0);
    step();
    host_valid = 0;
    check("t5_rvalid_before", host_rvalid, 1);
    reset_pulse();

    // Reset while the host has been waiting five cycles
    set_host(0, 32'h44, 0);
    for (int i = 0; i < 5; i++) begin
      core_req = 1; core_we = 0; core_addr = 32'h100;
      step();
    end
    reset_pulse();
    run_stream(12, acc, stalls);
    check("t5_accept_after_reset", acc, STARVE_EN ? LIMIT + 1 : 13);

    // Random traffic obeying both sides' hold rules
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        core_req   = ($urandom_range(0, 3) != 0);
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        core_wdata = $urandom;
        core_be    = 3'($urandom_range(0, 7));
      end
      if (!host_valid || last_g) begin
        host_valid = ($urandom_range(0, 2) == 0);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        host_wdata = $urandom;
        host_be    = 3'($urandom_range(0, 7));
      end
      step();
      if (obs_stall) check("no_double_stall", prev_obs_stall, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
